// File: rtl/int_ex_arbiter_if.sv
// int_ex_arbiter_if: issue-request and execute-input bundle around the integer execute arbiter
interface int_ex_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int PAYLOAD_W = 128,
  parameter int ROB_ID_W = 5,
  parameter int PTR_W = $clog2(N_REQ)
);
  logic [N_REQ-1:0] req_valid;
  logic [N_REQ-1:0] req_ready;
  logic [N_REQ*PAYLOAD_W-1:0] req_payload;
  logic [N_REQ*ROB_ID_W-1:0] req_rob_id;
  logic ex_valid;
  logic [PAYLOAD_W-1:0] ex_payload;
  logic [ROB_ID_W-1:0] ex_rob_id;
  logic ex_ready;
  logic flush;
  logic [ROB_ID_W-1:0] flush_rob_id;
  logic [ROB_ID_W-1:0] rob_head_id;
  logic [PTR_W-1:0] rr_ptr;
  modport master (
    output req_valid, req_payload, req_rob_id, ex_ready, flush, flush_rob_id, rob_head_id,
    input req_ready, ex_valid, ex_payload, ex_rob_id, rr_ptr
  );
  modport slave (
    input req_valid, req_payload, req_rob_id, ex_ready, flush, flush_rob_id, rob_head_id,
    output req_ready, ex_valid, ex_payload, ex_rob_id, rr_ptr
  );
endinterface

// File: rtl/int_ex_arbiter.sv
// int_ex_arbiter: round-robin share of the integer execute unit with flush squash
module int_ex_arbiter #(
  parameter int N_REQ = 2,
  parameter int PAYLOAD_W = 128,
  parameter int ROB_ID_W = 5,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input logic clk,
  input logic rst,
  int_ex_arbiter_if.slave bus
);
  logic [PAYLOAD_W-1:0] pay [N_REQ];
  logic [ROB_ID_W-1:0] rob [N_REQ];
  logic [PTR_W-1:0] winner, rr_nxt;
  logic found, can_load, xfer, kill;
  logic [ROB_ID_W-1:0] ex_age, fl_age;
  int c;
  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign pay[g] = bus.req_payload[g*PAYLOAD_W +: PAYLOAD_W];
    assign rob[g] = bus.req_rob_id[g*ROB_ID_W +: ROB_ID_W];
  end
  // circular scan from rr_ptr; iterations run farthest-first so the nearest valid requester wins
  always_comb begin
    winner = bus.rr_ptr;
    found = 1'b0;
    c = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      c = (int'(bus.rr_ptr) + k) % N_REQ;
      if (bus.req_valid[c[PTR_W-1:0]]) begin
        winner = c[PTR_W-1:0];
        found = 1'b1;
      end
    end
  end
  // grant gating, ROB-age squash decision and next pointer
  always_comb begin
    can_load = !bus.ex_valid | bus.ex_ready;
    ex_age = bus.ex_rob_id - bus.rob_head_id;
    fl_age = bus.flush_rob_id - bus.rob_head_id;
    kill = bus.flush & bus.ex_valid & (ex_age > fl_age);
    bus.req_ready = (can_load & !bus.flush & found) ? N_REQ'(1) << winner : '0;
    xfer = |(bus.req_valid & bus.req_ready);
    rr_nxt = (winner == PTR_W'(N_REQ - 1)) ? '0 : winner + 1'b1;
  end
  // execute-input pipeline register and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ex_valid <= 1'b0;
      bus.ex_payload <= '0;
      bus.ex_rob_id <= '0;
      bus.rr_ptr <= '0;
    end else if (xfer) begin
      bus.ex_valid <= 1'b1;
      bus.ex_payload <= pay[winner];
      bus.ex_rob_id <= rob[winner];
      bus.rr_ptr <= rr_nxt;
    end else if (kill || (bus.ex_valid && bus.ex_ready)) begin
      bus.ex_valid <= 1'b0;
    end
  end
  a_onehot: assert property (@(posedge clk) $onehot0(bus.req_ready));
  a_stable: assert property (@(posedge clk) disable iff (rst)
    bus.ex_valid && !bus.ex_ready && !bus.flush |=> $stable(bus.ex_payload));
endmodule
